snes_pad_serializer: RTL and testbench
======================================

// Module: snes_pad_serializer
// PURPOSE
// - Downstream consumer of the DB9 joystick shift-register decoder: takes its two 6-button active-low sets, debounces them,
//   and serves them to the SNES core as two SNES-protocol serial pads (latch + per-port clock in, serial data out).
// - All SNES-side strobes are internal fabric signals synchronous to clk; the joystick inputs are treated as asynchronous.
// PARAMETERS
// - DIV_W         16     width of debounce prescaler
// - DEBOUNCE_DIV  50000  clk cycles per debounce sample tick (1 ms at 50 MHz); legal range 2..2^DIV_W-1
// PORTS
// - clk            in   1  system clock
// - reset          in   1  synchronous, active-high reset
// - joy1_n         in   6  player 1 {up,down,left,right,fire1,fire2}, 0 = pressed, asynchronous
// - joy2_n         in   6  player 2, same layout
// - snes_latch     in   1  SNES pad latch, high = load
// - snes_clk1      in   1  SNES port 1 shift clock
// - snes_clk2      in   1  SNES port 2 shift clock
// - snes1_data_n   out  1  port 1 serial data, 0 = pressed
// - snes2_data_n   out  1  port 2 serial data, 0 = pressed
// - joy1_db_n      out  6  debounced player 1 buttons (status/OSD use)
// - joy2_db_n      out  6  debounced player 2 buttons
// BEHAVIOUR
// - Reset: joyN_db_n=6'h3F, shift regs all 1, snesN_data_n=1, bit counters 0, prescaler 0, sync/history regs all 1.
// - Input sync: each joy bit through 2 flops before use.
// - Prescaler counts 0..DEBOUNCE_DIV-1, wraps; one-cycle tick at wrap. On tick each synced bit is sampled into a 2-deep
//   history; db bit takes the sample only when sample == both history entries (3 consecutive equal ticks), else holds.
//   Change latency: 2 sync cycles + up to 3 ticks. Pulse shorter than 2 ticks never reaches db outputs.
// - 16-bit frame per port, bit 0 sent first, 0 = pressed:
//   0 B=fire1, 1 Y=1, 2 Select=1, 3 Start=1, 4 Up, 5 Down, 6 Left, 7 Right, 8 A=fire2, 9..11 X/L/R=1, 12..15 ID=1.
// - Edges: snes_latch and snes_clkN registered once; rise = cur & ~prev. Falling edges ignored.
// - While snes_latch=1: both shift regs reload from current db frame every cycle, counters forced to 0,
//   snesN_data_n = frame bit 0 (registered, valid cycle after load).
// - snes_latch=0, rising edge on snes_clkN: port N shift right 1 (fill 1), counter +1 saturating at 16.
//   data_n = sr[0] while counter<16; counter==16 -> data_n=0 (standard pad, reads as 1 on CPU side), held until next latch.
// - Ports fully independent; clk1 and clk2 edges in same cycle both act.
// - Simultaneous latch=1 and clock rise: latch wins, no shift, counter 0.
// - Frame frozen after latch falls: db changes mid-frame do not alter bits being shifted.
// - Reset mid-frame: all state to reset values next cycle; a frame is only served again after a new latch.
// CONFIGURATION
// - JOY_COMBO_EN defined: fire1 & fire2 both pressed (db) -> Start bit 3 = 0 and B, A bits forced 1; otherwise normal map.
// - JOY_COMBO_EN undefined: Start/Select always 1; fire1->B, fire2->A unconditionally. No combo logic present.
// TESTING
// - Reset, inputs 6'h3F: snesN_data_n=1, joyN_db_n=6'h3F; latch + 16 clocks -> sixteen 1s then 0.
// - DEBOUNCE_DIV=4, joy1_n=6'b111101 held: joy1_db_n changes on 3rd tick, not 2nd; 1-tick 0-pulse on up -> no change.
// - joy1_db_n=6'b011101 (up+fire1): latch, 16 clk1 rises -> data_n 0,1,1,1,0,1,1,1,1,1,1,1,1,1,1,1 then 0 on 17th+.
// - Latch high coincident with clk1 rise after 5 shifts -> counter 0, data_n = bit 0 again; port 2 unaffected by clk1.
// - Change joy1_n after bit 3 shifted, run past debounce -> remaining bits of frame unchanged; next latch shows new value.
// - fire1+fire2 pressed: with JOY_COMBO_EN bit0=1, bit3=0, bit8=1; without: bit0=0, bit3=1, bit8=0.

Source files
------------

// File: rtl/snes_pad_serializer.sv
// snes_pad_serializer
// Takes the two active-low 6-button sets from the DB9 joystick decoder.
// Synchronises and debounces both sets, then serves each one to the SNES core
// as a standard 16-bit serial pad. The SNES strobes are fabric signals that are
// synchronous to clk.
//
// Optional build macro:
//   JOY_COMBO_EN - when fire1 and fire2 are both pressed, Start is reported
//                  and B/A are suppressed.
//
// Ports:
//   clk           system clock
//   reset         synchronous, active-high reset
//   joy1_n/joy2_n {up,down,left,right,fire1,fire2}, 0 = pressed, asynchronous
//   snes_latch    pad latch, high = load both ports
//   snes_clk1/2   per-port shift clocks
//   snes1/2_data_n serial data per port, 0 = pressed
//   joy1/2_db_n   debounced button sets
module snes_pad_serializer #(
    parameter int DIV_W        = 16,
    parameter int DEBOUNCE_DIV = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] joy1_n,
    input  logic [5:0] joy2_n,
    input  logic       snes_latch,
    input  logic       snes_clk1,
    input  logic       snes_clk2,
    output logic       snes1_data_n,
    output logic       snes2_data_n,
    output logic [5:0] joy1_db_n,
    output logic [5:0] joy2_db_n
);

    // Index 0 is player/port 1, index 1 is player/port 2.
    logic [1:0][5:0]  joy_raw;
    logic [1:0][5:0]  meta_q, sync_q, hist1_q, hist2_q, db_q, db_d;
    logic [1:0][5:0]  agree;
    logic [DIV_W-1:0] div_q, div_d;
    logic             tick;

    logic             latch_q;
    logic [1:0]       sclk_q, sclk_prev_q, rise;
    logic [1:0][15:0] sr_q, sr_d;
    logic [1:0][4:0]  cnt_q, cnt_d;
    logic [1:0]       data_q, data_d;

    assign joy_raw = {joy2_n, joy1_n};

    // Map one debounced button set onto the 16-bit SNES frame (bit 0 sent first).
    function automatic logic [15:0] build_frame(input logic [5:0] b);
        logic [15:0] f;
        f    = '1;
        f[0] = b[1];   // B      <- fire1
        f[4] = b[5];   // Up
        f[5] = b[4];   // Down
        f[6] = b[3];   // Left
        f[7] = b[2];   // Right
        f[8] = b[0];   // A      <- fire2
`ifdef JOY_COMBO_EN
        // fire1+fire2 together acts as Start instead of B+A.
        if (!b[1] && !b[0]) begin
            f[0] = 1'b1;
            f[8] = 1'b1;
            f[3] = 1'b0;
        end
`endif
        return f;
    endfunction

    // ---------------- debounce ----------------
    assign tick  = (div_q == DIV_W'(DEBOUNCE_DIV - 1));
    assign div_d = tick ? '0 : div_q + DIV_W'(1);

    // A bit follows the new sample only after three consecutive ticks agree.
    assign agree = ~(sync_q ^ hist1_q) & ~(sync_q ^ hist2_q);
    assign db_d  = tick ? ((agree & sync_q) | (~agree & db_q)) : db_q;

    // ---------------- serializer ----------------
    assign rise = sclk_q & ~sclk_prev_q;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        sr_d   = sr_q;
        cnt_d  = cnt_q;
        data_d = data_q;
        for (int p = 0; p < 2; p++) begin
            if (latch_q) begin
                // Latch has priority over a coincident clock rise.
                sr_d[p]  = build_frame(db_q[p]);
                cnt_d[p] = 5'd0;
            end else if (rise[p]) begin
                sr_d[p]  = {1'b1, sr_q[p][15:1]};
                cnt_d[p] = (cnt_q[p] == 5'd16) ? 5'd16 : cnt_q[p] + 5'd1;
            end
            // After all 16 bits a standard pad drives 0 until the next latch.
            data_d[p] = (cnt_d[p] == 5'd16) ? 1'b0 : sr_d[p][0];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q      <= '1;
            sync_q      <= '1;
            hist1_q     <= '1;
            hist2_q     <= '1;
            db_q        <= '1;
            div_q       <= '0;
            latch_q     <= 1'b0;
            sclk_q      <= '0;
            sclk_prev_q <= '0;
            sr_q        <= '1;
            cnt_q       <= '0;
            data_q      <= '1;
        end else begin
            meta_q      <= joy_raw;
            sync_q      <= meta_q;
            div_q       <= div_d;
            db_q        <= db_d;
            if (tick) begin
                hist1_q <= sync_q;
                hist2_q <= hist1_q;
            end
            latch_q     <= snes_latch;
            sclk_q      <= {snes_clk2, snes_clk1};
            sclk_prev_q <= sclk_q;
            sr_q        <= sr_d;
            cnt_q       <= cnt_d;
            data_q      <= data_d;
        end
    end

    assign snes1_data_n = data_q[0];
    assign snes2_data_n = data_q[1];
    assign joy1_db_n    = db_q[0];
    assign joy2_db_n    = db_q[1];

endmodule

// File: tb/tb_snes_pad_serializer.sv
// Bench for snes_pad_serializer. The reference model tracks, per port, the
// debounced button set, the frame captured at the last latch, and how many bits
// have been shifted out. A compare process checks every cycle against that model.
module tb_snes_pad_serializer;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] joy1_n, joy2_n;
    logic       snes_latch, snes_clk1, snes_clk2;
    logic       snes1_data_n, snes2_data_n;
    logic [5:0] joy1_db_n, joy2_db_n;

    snes_pad_serializer #(.DIV_W(16), .DEBOUNCE_DIV(DIV)) dut (
        .clk          (clk),
        .reset        (reset),
        .joy1_n       (joy1_n),
        .joy2_n       (joy2_n),
        .snes_latch   (snes_latch),
        .snes_clk1    (snes_clk1),
        .snes_clk2    (snes_clk2),
        .snes1_data_n (snes1_data_n),
        .snes2_data_n (snes2_data_n),
        .joy1_db_n    (joy1_db_n),
        .joy2_db_n    (joy2_db_n)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state.
    logic [5:0]  m_db    [2];
    logic [15:0] m_frame [2];
    int          m_idx   [2];
    bit          chk_data = 0;
    bit          chk_db   = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame assembled from named buttons, bit 0 in the LSB.
    function automatic logic [15:0] ref_frame(input logic [5:0] b);
        logic up, down, left, right, f1, f2, btn_b, btn_a, start;
        {up, down, left, right, f1, f2} = b;
        btn_b = f1;
        btn_a = f2;
        start = 1'b1;
`ifdef JOY_COMBO_EN
        if (!f1 && !f2) begin
            btn_b = 1'b1;
            btn_a = 1'b1;
            start = 1'b0;
        end
`endif
        // ID[15:12], R, L, X, A, Right, Left, Down, Up, Start, Select, Y, B
        return {4'hF, 3'b111, btn_a, right, left, down, up, start, 1'b1, 1'b1, btn_b};
    endfunction

    function automatic logic exp_bit(input int p);
        logic [15:0] f;
        f = m_frame[p];
        return (m_idx[p] >= 16) ? 1'b0 : f[m_idx[p]];
    endfunction

    // Compare process: DUT vs model on every falling edge.
    always @(negedge clk) begin
        if (chk_data) begin
            check("port1_data", {15'd0, snes1_data_n}, {15'd0, exp_bit(0)});
            check("port2_data", {15'd0, snes2_data_n}, {15'd0, exp_bit(1)});
        end
        if (chk_db) begin
            check("joy1_db", {10'd0, joy1_db_n}, {10'd0, m_db[0]});
            check("joy2_db", {10'd0, joy2_db_n}, {10'd0, m_db[1]});
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One shift-clock pulse on the selected ports.
    task automatic pulse(input bit c1, input bit c2);
        chk_data  = 0;
        snes_clk1 = c1;
        snes_clk2 = c2;
        cyc(2);
        snes_clk1 = 1'b0;
        snes_clk2 = 1'b0;
        if (c1 && m_idx[0] < 16) m_idx[0]++;
        if (c2 && m_idx[1] < 16) m_idx[1]++;
        cyc(2);
        chk_data = 1;
        cyc(2);
    endtask

    task automatic do_latch();
        chk_data   = 0;
        snes_latch = 1'b1;
        cyc(3);
        snes_latch = 1'b0;
        for (int p = 0; p < 2; p++) begin
            m_frame[p] = ref_frame(m_db[p]);
            m_idx[p]   = 0;
        end
        cyc(2);
        chk_data = 1;
        cyc(2);
    endtask

    // Change the joystick inputs and wait well past the debounce latency.
    task automatic set_joy(input logic [5:0] j1, input logic [5:0] j2);
        chk_db = 0;
        joy1_n = j1;
        joy2_n = j2;
        cyc(24);
        m_db[0] = j1;
        m_db[1] = j2;
        chk_db  = 1;
        cyc(2);
    endtask

    // Shift out a full frame on port 1, sampling data before each clock.
    task automatic read_port1(output logic [15:0] v);
        for (int i = 0; i < 16; i++) begin
            v[i] = snes1_data_n;
            pulse(1'b1, 1'b0);
        end
    endtask

    logic [15:0] got;
    int          n;
    bit          seen;

    initial begin
        reset      = 1'b1;
        joy1_n     = 6'h3F;
        joy2_n     = 6'h3F;
        snes_latch = 1'b0;
        snes_clk1  = 1'b0;
        snes_clk2  = 1'b0;
        cyc(3);
        reset = 1'b0;
        for (int p = 0; p < 2; p++) begin
            m_db[p]    = 6'h3F;
            m_frame[p] = 16'hFFFF;
            m_idx[p]   = 0;
        end

        // Pin the model against hand-derived frames.
        check("model_frame_up_fire1", ref_frame(6'b011101), 16'hFFEE);
        check("model_frame_idle", ref_frame(6'h3F), 16'hFFFF);

        // Reset state.
        check("reset_data1", {15'd0, snes1_data_n}, 16'd1);
        check("reset_data2", {15'd0, snes2_data_n}, 16'd1);
        check("reset_db1", {10'd0, joy1_db_n}, 16'h3F);
        check("reset_db2", {10'd0, joy2_db_n}, 16'h3F);
        chk_data = 1;
        chk_db   = 1;
        cyc(4);

        // Idle pad: sixteen 1s then 0.
        do_latch();
        for (int i = 0; i < 18; i++) pulse(1'b1, 1'b1);
        check("idle_after16_data1", {15'd0, snes1_data_n}, 16'd0);

        // Debounce latency: the change must land on the third tick.
        chk_db = 0;
        joy1_n = 6'b111101;
        n      = 0;
        seen   = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            cyc(1);
            n++;
            if (joy1_db_n != 6'h3F) seen = 1;
        end
        total++;
        if (!seen || n < 11 || n > 14) begin
            bad++;
            $display("FAIL db_latency: actual=%0d cycles (seen=%0d) required=11..14", n, seen);
        end
        check("db_value_fire1", {10'd0, joy1_db_n}, 16'h3D);
        m_db[0] = 6'b111101;
        chk_db  = 1;
        cyc(4);

        // A pulse of one tick period on 'up' never reaches the debounced output.
        joy1_n = 6'b011101;
        cyc(DIV);
        joy1_n = 6'b111101;
        cyc(30);
        check("short_pulse_ignored", {10'd0, joy1_db_n}, 16'h3D);

        // up + fire1 frame on port 1.
        set_joy(6'b011101, 6'h3F);
        do_latch();
        read_port1(got);
        check("frame_up_fire1", got, 16'hFFEE);
        pulse(1'b1, 1'b0);
        check("port1_17th_zero", {15'd0, snes1_data_n}, 16'd0);
        check("port2_untouched", {15'd0, snes2_data_n}, 16'd1);

        // Latch coincident with a clk1 rise: latch wins.
        do_latch();
        repeat (5) pulse(1'b1, 1'b0);
        repeat (2) pulse(1'b0, 1'b1);
        chk_data   = 0;
        snes_latch = 1'b1;
        snes_clk1  = 1'b1;
        cyc(3);
        snes_latch = 1'b0;
        cyc(2);
        snes_clk1 = 1'b0;
        m_idx[0]  = 0;
        m_idx[1]  = 0;
        cyc(2);
        chk_data = 1;
        check("latch_wins_bit0", {15'd0, snes1_data_n}, 16'd0);
        cyc(2);

        // Frame frozen after the latch falls.
        do_latch();
        repeat (4) pulse(1'b1, 1'b0);
        set_joy(6'b111110, 6'h3F);
        repeat (13) pulse(1'b1, 1'b0);
        do_latch();
        check("new_frame_bit0", {15'd0, snes1_data_n}, 16'd1);
        read_port1(got);
        check("frame_fire2", got, 16'hFEFF);

        // fire1 + fire2 together.
        set_joy(6'b111100, 6'b111100);
        do_latch();
        read_port1(got);
`ifdef JOY_COMBO_EN
        check("combo_frame", got, 16'hFFF7);
`else
        check("combo_frame", got, 16'hFEFE);
`endif

        // Randomized traffic.
        for (int it = 0; it < 30; it++) begin
            set_joy(6'($urandom), 6'($urandom));
            do_latch();
            for (int k = 0; k < int'($urandom_range(20, 0)); k++) begin
                case ($urandom_range(2, 0))
                    0:       pulse(1'b1, 1'b0);
                    1:       pulse(1'b0, 1'b1);
                    default: pulse(1'b1, 1'b1);
                endcase
                if ($urandom_range(7, 0) == 0) set_joy(6'($urandom), 6'($urandom));
            end
        end

        // Reset in the middle of a frame.
        set_joy(6'b010101, 6'b101010);
        do_latch();
        repeat (3) pulse(1'b1, 1'b1);
        chk_data = 0;
        chk_db   = 0;
        reset    = 1'b1;
        cyc(1);
        check("midreset_data1", {15'd0, snes1_data_n}, 16'd1);
        check("midreset_data2", {15'd0, snes2_data_n}, 16'd1);
        check("midreset_db1", {10'd0, joy1_db_n}, 16'h3F);
        check("midreset_db2", {10'd0, joy2_db_n}, 16'h3F);
        reset = 1'b0;
        for (int p = 0; p < 2; p++) begin
            m_frame[p] = 16'hFFFF;
            m_idx[p]   = 0;
        end
        chk_data = 1;
        set_joy(6'b010101, 6'b101010);
        do_latch();
        repeat (17) pulse(1'b1, 1'b1);

        chk_data = 0;
        chk_db   = 0;
        cyc(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
